// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column low at a time, debounces whole scan
// frames and emits a one-cycle event for each clean single-key press.
module keypad_scanner #(
   parameter int SCAN_DIV       = 25000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int SW = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
   localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_SCANS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HELD  = 2'd1;
   localparam logic [1:0] ST_MULTI = 2'd2;

   logic [3:0]    rowMeta_q, rowSync_q;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    colIdx_q, colIdx_d;
   logic [3:0]    col_q, col_d;
   logic [15:0]   rawFrame_q, rawFrame_d;
   logic [15:0]   prevFrame_q, prevFrame_d;
   logic [15:0]   debFrame_q, debFrame_d;
   logic [SW-1:0] stable_q, stable_d;
   logic          debUpd_q, debUpd_d;
   logic [1:0]    state_q, state_d;
   logic [3:0]    keyCode_q, keyCode_d;
   logic          keyValid_q, keyValid_d;
   logic          keyHeld_q, keyHeld_d;

   logic          tick, frameDone, debEmpty, debSingle;
   logic [3:0]    debIdx;

   // Scan timing and raw-frame capture; the sample always belongs to the column
   // that has been driven for the whole dwell.
   always_comb begin
      tick      = (dwell_q == DWELL_LAST);
      frameDone = tick && (colIdx_q == 2'd3);
      dwell_d   = tick ? '0 : dwell_q + 1'b1;
      colIdx_d  = tick ? colIdx_q + 2'd1 : colIdx_q;
      col_d     = ~(4'b0001 << colIdx_d);
      rawFrame_d = rawFrame_q;
      if (tick) begin
         for (int r = 0; r < 4; r++) begin
            rawFrame_d[{2'(r), colIdx_q}] = ~rowSync_q[r];
         end
      end
   end

   always_comb begin
      prevFrame_d = prevFrame_q;
      stable_d    = stable_q;
      debFrame_d  = debFrame_q;
      debUpd_d    = 1'b0;
      if (frameDone) begin
         if (rawFrame_d == prevFrame_q) begin
            stable_d = (stable_q == STABLE_LAST) ? stable_q : stable_q + 1'b1;
         end else begin
            stable_d = '0;
         end
         prevFrame_d = rawFrame_d;
         if (stable_d == STABLE_LAST) begin
            debFrame_d = rawFrame_d;
            debUpd_d   = 1'b1;
         end
      end
   end

   // Bit position of the debounced frame equals row*4+col, i.e. the key code.
   always_comb begin
      debEmpty  = (debFrame_q == 16'd0);
      debSingle = !debEmpty && ((debFrame_q & (debFrame_q - 16'd1)) == 16'd0);
      debIdx    = 4'd0;
      for (int b = 0; b < 16; b++) begin
         if (debFrame_q[b]) debIdx = 4'(b);
      end
   end

   always_comb begin
      state_d    = state_q;
      keyCode_d  = keyCode_q;
      keyValid_d = 1'b0;
      keyHeld_d  = keyHeld_q;
      if (debUpd_q) begin
         case (state_q)
            ST_IDLE: begin
               if (debSingle) begin
                  keyCode_d  = debIdx;
                  keyValid_d = 1'b1;
                  keyHeld_d  = 1'b1;
                  state_d    = ST_HELD;
               end else if (!debEmpty) begin
                  state_d = ST_MULTI;
               end
            end
            ST_HELD: begin
               if (debEmpty) begin
                  keyHeld_d = 1'b0;
                  state_d   = ST_IDLE;
               end
            end
            ST_MULTI: begin
               if (debEmpty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rowMeta_q   <= 4'hF;
         rowSync_q   <= 4'hF;
         dwell_q     <= '0;
         colIdx_q    <= 2'd0;
         col_q       <= 4'b1110;
         rawFrame_q  <= '0;
         prevFrame_q <= '0;
         debFrame_q  <= '0;
         stable_q    <= '0;
         debUpd_q    <= 1'b0;
         state_q     <= ST_IDLE;
         keyCode_q   <= 4'd0;
         keyValid_q  <= 1'b0;
         keyHeld_q   <= 1'b0;
      end else begin
         rowMeta_q   <= row;
         rowSync_q   <= rowMeta_q;
         dwell_q     <= dwell_d;
         colIdx_q    <= colIdx_d;
         col_q       <= col_d;
         rawFrame_q  <= rawFrame_d;
         prevFrame_q <= prevFrame_d;
         debFrame_q  <= debFrame_d;
         stable_q    <= stable_d;
         debUpd_q    <= debUpd_d;
         state_q     <= state_d;
         keyCode_q   <= keyCode_d;
         keyValid_q  <= keyValid_d;
         keyHeld_q   <= keyHeld_d;
      end
   end

   assign col       = col_q;
   assign key_code  = keyCode_q;
   assign key_valid = keyValid_q;
   assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a physical 4x4 matrix and compares the DUT every
// cycle against a frame-level reference model, plus directed scenario checks.
module tb_keypad_scanner;

   localparam int S = 4;
   localparam int D = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] pressed = 16'd0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   int total = 0;
   int bad = 0;
   int pulses = 0;

   keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_SCANS(D)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // Physical matrix: a pressed key pulls its row low while its column is strobed.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: scan position from the cycle count, frames as 16-bit words.
   typedef enum {M_IDLE, M_HELD, M_MULTI} mstate_t;
   int          mCount = 0;
   logic [3:0]  mHist0 = 4'hF, mHist1 = 4'hF;
   logic [15:0] mFrame = 16'd0, mPrev = 16'd0, mDeb = 16'd0;
   int          mStable = 0;
   bit          mPend = 1'b0;
   mstate_t     mState = M_IDLE;
   logic        eValid = 1'b0, eHeld = 1'b0;
   logic [3:0]  eCode = 4'd0;

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            mCount = 0; mHist0 = 4'hF; mHist1 = 4'hF;
            mFrame = 16'd0; mPrev = 16'd0; mDeb = 16'd0;
            mStable = 0; mPend = 1'b0; mState = M_IDLE;
            eValid = 1'b0; eHeld = 1'b0; eCode = 4'd0;
         end else begin
            eValid = 1'b0;
            if (mPend) begin
               mPend = 1'b0;
               case (mState)
                  M_IDLE: begin
                     if ($countones(mDeb) == 1) begin
                        for (int b = 0; b < 16; b++) if (mDeb[b]) eCode = 4'(b);
                        eValid = 1'b1;
                        eHeld  = 1'b1;
                        mState = M_HELD;
                     end else if ($countones(mDeb) > 1) begin
                        mState = M_MULTI;
                     end
                  end
                  M_HELD:  if (mDeb == 16'd0) begin eHeld = 1'b0; mState = M_IDLE; end
                  M_MULTI: if (mDeb == 16'd0) mState = M_IDLE;
                  default: mState = M_IDLE;
               endcase
            end
            if (mCount % S == S - 1) begin
               for (int r = 0; r < 4; r++) mFrame[r*4 + (mCount / S) % 4] = !mHist1[r];
               if ((mCount / S) % 4 == 3) begin
                  if (mFrame == mPrev) begin
                     if (mStable < D - 1) mStable++;
                  end else begin
                     mStable = 0;
                  end
                  mPrev = mFrame;
                  if (mStable == D - 1) begin
                     mDeb  = mFrame;
                     mPend = 1'b1;
                  end
               end
            end
            mHist1 = mHist0;
            mHist0 = row;
            mCount++;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] one;
      logic [3:0] expCol;
      one    = 4'b0001;
      expCol = ~(one << ((mCount / S) % 4));
      checkOutput("col", 16'(col), 16'(expCol));
      checkOutput("key_code", 16'(key_code), 16'(eCode));
      checkOutput("key_valid", 16'(key_valid), 16'(eValid));
      checkOutput("key_held", 16'(key_held), 16'(eHeld));
      if (key_valid) pulses++;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] keys, input int cycles);
      pressed = keys;
      waitCycles(cycles);
   endtask

   initial begin
      int  p0;
      bit  found;
      logic [15:0] k;

      $display("[TB] start");
      waitCycles(3);
      reset = 1'b1;
      waitCycles(20);

      // Scenario 1: asynchronous reset between edges, then column rotation.
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("t1_col_async", 16'(col), 16'h000E);
      checkOutput("t1_code_async", 16'(key_code), 16'h0);
      checkOutput("t1_valid_async", 16'(key_valid), 16'h0);
      checkOutput("t1_held_async", 16'(key_held), 16'h0);
      @(negedge clk);
      reset = 1'b1;
      waitCycles(3);
      checkOutput("t1_col0", 16'(col), 16'h000E);
      waitCycles(4);
      checkOutput("t1_col1", 16'(col), 16'h000D);
      waitCycles(4);
      checkOutput("t1_col2", 16'(col), 16'h000B);
      waitCycles(4);
      checkOutput("t1_col3", 16'(col), 16'h0007);
      waitCycles(4);
      checkOutput("t1_colwrap", 16'(col), 16'h000E);

      // Scenario 2: clean press of key (1,2).
      p0 = pulses;
      pressed = 16'h0040;
      found = 1'b0;
      for (int i = 0; i < 67 && !found; i++) begin
         @(negedge clk);
         if (key_valid) found = 1'b1;
      end
      checkOutput("t2_latency", 16'(found), 16'h1);
      waitCycles(40);
      checkOutput("t2_pulses", 16'(pulses - p0), 16'h1);
      checkOutput("t2_code", 16'(key_code), 16'h6);
      checkOutput("t2_held", 16'(key_held), 16'h1);
      applyStimulus(16'h0000, 70);
      checkOutput("t2_release", 16'(key_held), 16'h0);

      // Scenario 3: key (3,0) bouncing every 5 clocks, then held.
      p0 = pulses;
      for (int i = 0; i < 12; i++) applyStimulus((i % 2 == 0) ? 16'h1000 : 16'h0000, 5);
      checkOutput("t3_bounce_pulses", 16'(pulses - p0), 16'h0);
      applyStimulus(16'h1000, 80);
      checkOutput("t3_pulses", 16'(pulses - p0), 16'h1);
      checkOutput("t3_code", 16'(key_code), 16'hC);
      applyStimulus(16'h0000, 70);

      // Scenario 4: two keys together never produce an event.
      p0 = pulses;
      applyStimulus(16'h0801, 80);
      checkOutput("t4_multi_pulses", 16'(pulses - p0), 16'h0);
      checkOutput("t4_multi_held", 16'(key_held), 16'h0);
      applyStimulus(16'h0000, 70);
      applyStimulus(16'h0002, 80);
      checkOutput("t4_pulses", 16'(pulses - p0), 16'h1);
      checkOutput("t4_code", 16'(key_code), 16'h1);
      applyStimulus(16'h0000, 70);

      // Scenario 5: release, repress, then add a second key while held.
      p0 = pulses;
      applyStimulus(16'h8000, 80);
      checkOutput("t5_first", 16'(pulses - p0), 16'h1);
      checkOutput("t5_code", 16'(key_code), 16'hF);
      applyStimulus(16'h0000, 70);
      checkOutput("t5_released", 16'(key_held), 16'h0);
      checkOutput("t5_code_kept", 16'(key_code), 16'hF);
      applyStimulus(16'h8000, 80);
      checkOutput("t5_repress", 16'(pulses - p0), 16'h2);
      applyStimulus(16'h8001, 80);
      checkOutput("t5_added", 16'(pulses - p0), 16'h2);
      checkOutput("t5_added_held", 16'(key_held), 16'h1);
      applyStimulus(16'h0000, 70);

      // Scenario 6: reset while a key is held.
      pressed = 16'h0020;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (key_held) found = 1'b1;
      end
      checkOutput("t6_held", 16'(found), 16'h1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("t6_rst_held", 16'(key_held), 16'h0);
      checkOutput("t6_rst_code", 16'(key_code), 16'h0);
      checkOutput("t6_rst_col", 16'(col), 16'h000E);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      p0 = pulses;
      waitCycles(80);
      checkOutput("t6_pulses", 16'(pulses - p0), 16'h1);
      checkOutput("t6_code", 16'(key_code), 16'h5);
      applyStimulus(16'h0000, 70);

      // Randomized presses, holds, releases and occasional second keys.
      for (int i = 0; i < 25; i++) begin
         k = 16'd1 << $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) k = k | (16'd1 << $urandom_range(0, 15));
         applyStimulus(k, $urandom_range(5, 90));
         applyStimulus(16'h0000, $urandom_range(5, 90));
      end
      applyStimulus(16'h0000, 70);
      checkOutput("final_held", 16'(key_held), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad for time entry on the kitchen timer. It strobes one column low at a time, mirroring how the display driver strobes its anodes. The block samples the active-low rows and debounces whole-keypad scan frames. For each clean single-key press it emits a one-cycle event carrying a 4-bit key code, which the timer control logic consumes.

Parameters:
SCAN_DIV, 25000, clocks each column stays active (dwell); must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full-scan frames required before a frame is accepted; must be >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
row  input  4  keypad rows; active-low with external pull-ups; asynchronous to clk
col  output  4  column strobes; exactly one bit low at any time
key_code  output  4  code of the last accepted key: row*4 + col
key_valid  output  1  one-cycle pulse when a new single-key press is accepted
key_held  output  1  high while the accepted single key stays debounced-pressed

Behaviour:
- Reset (reset=0) takes effect immediately, with no clock required. Reset values:
  - col=4'b1110 (column 0 active)
  - key_code=0, key_valid=0, key_held=0
  - state IDLE
  - dwell counter, column index, frame registers and stable counter all 0
- Reset may assert mid-operation, including mid-hold. All of the above is forced and nothing is remembered. After reset is released, a key that is still held is treated as a new press.
- Row synchronizer: two flops on row. All logic uses only the synchronized value.
- Dwell counter: counts 0..SCAN_DIV-1 and wraps.
  - The terminal count is the "tick".
  - On tick, sample the synchronized row into the raw-frame bits {row r, current col} as pressed = ~row[r].
  - On the same tick, advance the column index 0->1->2->3->0. col is registered and equals ~(1<<index).
  - The sample always belongs to the column that was active for the whole dwell. SCAN_DIV>=4 leaves at least 2 settle clocks after the synchronizer.
- Frame completion: the tick that samples column 3 completes a 16-bit raw frame. One scan is 4*SCAN_DIV clocks.
- Debounce, evaluated on each frame completion:
  - If raw frame == previous raw frame, stable_cnt increments, saturating at DEBOUNCE_SCANS-1.
  - Otherwise stable_cnt=0.
  - When stable_cnt reaches DEBOUNCE_SCANS-1, the raw frame is copied to the debounced frame. This is the DEBOUNCE_SCANS-th identical frame.
- Key state machine, updated on the clock after a debounced-frame update:
  - IDLE: debounced frame all zero -> stay. Exactly one bit set -> latch key_code, pulse key_valid for 1 clock, set key_held=1, go HELD. Two or more bits set -> go MULTI, no pulse.
  - HELD: debounced frame all zero -> key_held=0, go IDLE. Any nonzero frame, including an added second key -> stay, no new pulse, key_code unchanged.
  - MULTI: debounced frame all zero -> go IDLE. Otherwise stay. key_held stays 0.
- Ghost/multi-key presses never generate events. A new event requires a full debounced release first (no auto-repeat).
- key_code holds its value after release until the next accepted press.
- key_valid latency: asserted exactly 1 clock after the frame-completion tick of the qualifying scan.
- Worst-case latency from a stable press is (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 clocks.
- key_valid is never high on two consecutive clocks.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3, so one scan is 16 clocks.
1. Reset: assert reset=0 asynchronously between clock edges -> col=1110, key_code=0, key_valid=0 and key_held=0 immediately. With no keys pressed, col then rotates 1110,1101,1011,0111 every 4 clocks after release.
2. Clean press: model key (row1,col2) pressing row[1] low while col[2]=0 and hold it -> exactly one key_valid pulse within 67 clocks, key_code=6, key_held=1. key_valid stays 0 thereafter while held.
3. Bounce: toggle key (row3,col0) contact every 5 clocks for 60 clocks, then hold it stable -> no pulse during the bounce, then exactly one pulse with key_code=12.
4. Multi-key: press (0,0) and (2,3) together -> no key_valid and key_held=0. Release both, then press (0,1) -> one pulse, key_code=1.
5. Release and repress: hold (3,3) -> pulse, code 15. Release -> key_held falls after 3 clean empty scans and key_code stays 15. Repress -> second pulse. Add a second key while HELD -> no pulse.
6. Reset mid-hold: hold (1,1) until key_held=1, pulse reset for 3 clocks with the key still held -> outputs cleared. After release, one new pulse with key_code=5.
